wb_core_arbiter: RTL
====================

WB_CORE_ARBITER -- requirements
Module: wb_core_arbiter

Interface
REQ-001 Parameter: AW, 24, word-address width of the shared memory port.
REQ-002 Parameter: WB_BASE, 32'h3000_0000, Wishbone window base; window is WB_BASE + [0, 4*2^AW).
REQ-003 Parameter: TIMEOUT, 255, cycles to wait for mem_ready before abort (used only with WB_TIMEOUT_EN).
REQ-004 Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  reset, synchronous, active-high.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic slave controls.
- wbs_sel_i  in  4  byte enables.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  one-cycle ack.
- wbs_dat_o  out  32  read data.
- core_req_i  in  1  core request, held until core_gnt_o.
- core_we_i  in  1  core write.
- core_be_i  in  4  core byte enables.
- core_addr_i  in  AW  core word address.
- core_wdata_i  in  32  core write data.
- core_gnt_o  out  1  one-cycle completion pulse.
- core_rdata_o  out  32  read data, valid with core_gnt_o.
- mem_req_o  out  1  shared memory request.
- mem_we_o  out  1  memory write.
- mem_be_o  out  4  memory byte enables.
- mem_addr_o  out  AW  memory word address.
- mem_wdata_o  out  32  memory write data.
- mem_rdata_i  in  32  memory read data, valid with mem_ready_i.
- mem_ready_i  in  1  one-cycle completion from memory, latency >= 1.
- err_o  out  1  sticky timeout flag.

Function
REQ-005 FSM states IDLE, GRANT_WB, GRANT_CORE, RESP; exactly one memory transaction outstanding.
REQ-006 WB request = wbs_cyc_i & wbs_stb_i & address in window; address out of window SHALL be acked the next cycle with wbs_dat_o = 0 and no memory access.
REQ-007 IDLE: sole requester wins; if both request, winner is the one not granted last (round-robin, last_grant resets to CORE so WB wins first tie).
REQ-008 GRANT_x: mem_req_o = 1 with the winner's fields registered at the grant cycle; WB address maps to mem_addr_o = wbs_adr_i[AW+1:2].
REQ-009 mem_req_o stays high until mem_ready_i; on mem_ready_i, capture mem_rdata_i and go to RESP.
REQ-010 RESP: pulse wbs_ack_o or core_gnt_o for exactly one cycle with captured data, update last_grant, return to IDLE; next grant can issue the following cycle.
REQ-011 Minimum latency request-to-completion: 3 cycles for memory latency 1.
REQ-012 WB request dropped (cyc low) mid-transaction: memory access completes, ack suppressed.
REQ-013 Read data outputs hold last value between completions; writes return the memory's rdata unchanged.

Reset
REQ-014 On wb_rst_i high at a clock edge: state IDLE, all outputs 0, last_grant = CORE, err_o = 0, timeout counter 0; reset mid-transaction abandons it without ack/gnt.

Configuration
REQ-015 Macro WB_TIMEOUT_EN defined: counter in GRANT_x; if mem_ready_i absent for TIMEOUT cycles, drop mem_req_o, set err_o sticky, complete requester with data 32'hDEAD_BEEF.
REQ-016 Macro undefined: no counter, err_o tied 0, wait indefinitely.

Verification
REQ-017 WB read 0x3000_0010, memory latency 1 returning 0x1234_5678 -> mem_addr_o = 4, wbs_ack_o one cycle, wbs_dat_o = 0x1234_5678, 3 cycles.
REQ-018 WB and core request same cycle after reset -> WB served first, core next; repeat tie -> order alternates.
REQ-019 WB access to 0x2000_0000 -> ack next cycle, dat 0, mem_req_o never asserted.
REQ-020 Core write be=4'b0011 addr 7 data 0xA5A5_A5A5, latency 5 -> mem fields held 5 cycles, single core_gnt_o.
REQ-021 WB_TIMEOUT_EN, TIMEOUT=255, memory never ready -> after 255 cycles err_o=1, wbs_dat_o=0xDEAD_BEEF acked; without macro, no ack.
REQ-022 wb_rst_i asserted mid GRANT_CORE -> next cycle all outputs 0, no core_gnt_o.

Source files
------------

// File: rtl/wb_core_arbiter_if.sv
// Bundles the Wishbone slave, core request and shared-memory port signals of wb_core_arbiter.
// Signal names keep their bus-level _i/_o suffixes as seen from the arbiter.
// slave modport: arbiter side. master modport: the environment (Wishbone master, core, memory).
interface wb_core_arbiter_if #(
    parameter int AW = 24
);
    // Wishbone classic slave port
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    // core request port
    logic          core_req_i;
    logic          core_we_i;
    logic [3:0]    core_be_i;
    logic [AW-1:0] core_addr_i;
    logic [31:0]   core_wdata_i;
    logic          core_gnt_o;
    logic [31:0]   core_rdata_o;
    // shared memory port
    logic          mem_req_o;
    logic          mem_we_o;
    logic [3:0]    mem_be_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic [31:0]   mem_rdata_i;
    logic          mem_ready_i;
    // status
    logic          err_o;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o,
        input  core_req_i, core_we_i, core_be_i, core_addr_i, core_wdata_i,
        output core_gnt_o, core_rdata_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i, mem_ready_i,
        output err_o
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o,
        output core_req_i, core_we_i, core_be_i, core_addr_i, core_wdata_i,
        input  core_gnt_o, core_rdata_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i, mem_ready_i,
        input  err_o
    );
endinterface

// File: rtl/wb_core_arbiter.sv
// Purpose: round-robin arbiter sharing one memory port between a Wishbone slave and a core.
// Latency: request-to-completion 3 cycles for 1-cycle memory; one transaction outstanding.
// Backpressure: requesters hold their request until ack/gnt; mem_req_o held until mem_ready_i.
// Ports: wb_clk_i, wb_rst_i (sync, active-high) plus all bus signals in wb_core_arbiter_if.slave.
// Optional: define WB_TIMEOUT_EN to abort a stalled access after TIMEOUT cycles (err_o, 0xDEAD_BEEF).
module wb_core_arbiter #(
    parameter int          AW      = 24,
    parameter logic [31:0] WB_BASE = 32'h3000_0000,
    parameter int          TIMEOUT = 255
) (
    input logic              wb_clk_i,
    input logic              wb_rst_i,
    wb_core_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GRANT_WB, GRANT_CORE, RESP} state_t;

    // 33-bit window bounds so a window ending at 2^32 cannot wrap
    localparam logic [32:0] WIN_LO = {1'b0, WB_BASE};
    localparam logic [32:0] WIN_HI = WIN_LO + (33'd1 << (AW + 2));

    state_t        state;
    logic          last_wb;   // last completed grant: 1 = WB, 0 = core
    logic          owner_wb;  // requester of the access in flight
    logic          wb_drop;   // WB master abandoned the cycle; swallow its ack
    logic          ack_q;
    logic [31:0]   dat_q;
    logic          gnt_q;
    logic [31:0]   rdata_q;
    logic          mreq_q;
    logic          mwe_q;
    logic [3:0]    mbe_q;
    logic [AW-1:0] maddr_q;
    logic [31:0]   mwdata_q;

    logic        in_win;
    logic        wb_req;
    logic        wb_bad;
    logic        tmo_hit;
    logic        done;
    logic [31:0] done_dat;

    assign in_win = ({1'b0, bus.wbs_adr_i} >= WIN_LO) && ({1'b0, bus.wbs_adr_i} < WIN_HI);
    // ack_q gates the cycle in which the master still holds stb over our own ack
    assign wb_req = bus.wbs_cyc_i && bus.wbs_stb_i && in_win && !ack_q;
    assign wb_bad = bus.wbs_cyc_i && bus.wbs_stb_i && !in_win && !ack_q;

`ifdef WB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;
    logic          err_q;
    // tmo_cnt + 1 cycles have elapsed without mem_ready_i
    assign tmo_hit   = (tmo_cnt == TW'(TIMEOUT - 1));
    assign bus.err_o = err_q;
`else
    assign tmo_hit   = 1'b0;
    assign bus.err_o = 1'b0;
`endif

    assign done     = bus.mem_ready_i || tmo_hit;
    assign done_dat = bus.mem_ready_i ? bus.mem_rdata_i : 32'hDEAD_BEEF;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= IDLE;
            last_wb  <= 1'b0;
            owner_wb <= 1'b0;
            wb_drop  <= 1'b0;
            ack_q    <= 1'b0;
            dat_q    <= '0;
            gnt_q    <= 1'b0;
            rdata_q  <= '0;
            mreq_q   <= 1'b0;
            mwe_q    <= 1'b0;
            mbe_q    <= '0;
            maddr_q  <= '0;
            mwdata_q <= '0;
`ifdef WB_TIMEOUT_EN
            tmo_cnt  <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            ack_q <= 1'b0;
            gnt_q <= 1'b0;
            case (state)
                IDLE: begin
`ifdef WB_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                    // out-of-window access: immediate zero-data ack, memory untouched
                    if (wb_bad) begin
                        ack_q <= 1'b1;
                        dat_q <= '0;
                    end
                    if (wb_req && (!bus.core_req_i || !last_wb)) begin
                        state    <= GRANT_WB;
                        owner_wb <= 1'b1;
                        wb_drop  <= 1'b0;
                        mreq_q   <= 1'b1;
                        mwe_q    <= bus.wbs_we_i;
                        mbe_q    <= bus.wbs_sel_i;
                        maddr_q  <= bus.wbs_adr_i[AW+1:2];
                        mwdata_q <= bus.wbs_dat_i;
                    end else if (bus.core_req_i) begin
                        state    <= GRANT_CORE;
                        owner_wb <= 1'b0;
                        wb_drop  <= 1'b0;
                        mreq_q   <= 1'b1;
                        mwe_q    <= bus.core_we_i;
                        mbe_q    <= bus.core_be_i;
                        maddr_q  <= bus.core_addr_i;
                        mwdata_q <= bus.core_wdata_i;
                    end
                end
                GRANT_WB, GRANT_CORE: begin
                    if (state == GRANT_WB && !bus.wbs_cyc_i) begin
                        wb_drop <= 1'b1;
                    end
                    if (done) begin
                        mreq_q <= 1'b0;
                        state  <= RESP;
                        if (!owner_wb) begin
                            gnt_q   <= 1'b1;
                            rdata_q <= done_dat;
                        end else if (bus.wbs_cyc_i && !wb_drop) begin
                            ack_q <= 1'b1;
                            dat_q <= done_dat;
                        end
                    end
`ifdef WB_TIMEOUT_EN
                    if (!done) begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                    if (!bus.mem_ready_i && tmo_hit) begin
                        err_q <= 1'b1;
                    end
`endif
                end
                RESP: begin
                    state   <= IDLE;
                    last_wb <= owner_wb;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.wbs_ack_o    = ack_q;
    assign bus.wbs_dat_o    = dat_q;
    assign bus.core_gnt_o   = gnt_q;
    assign bus.core_rdata_o = rdata_q;
    assign bus.mem_req_o    = mreq_q;
    assign bus.mem_we_o     = mwe_q;
    assign bus.mem_be_o     = mbe_q;
    assign bus.mem_addr_o   = maddr_q;
    assign bus.mem_wdata_o  = mwdata_q;
endmodule
